ac_executor: RTL
================

Name: ac_executor

Overview:
- Sequencer and storage for the accumulator (AC) and extend bit (E) of the basic computer.
- Accepts one AC-class operation code per request. For ALU-class operations it drives a one-hot operator select to the ALU for one cycle and registers the returned result. For the remaining operations it computes the result internally.
- Sits around the ALU: ac_out feeds the ALU AC input, and alu_ac_in/alu_c_in take the ALU outputs. The control unit issues requests.

Parameters:
- none (datapath fixed at 16-bit AC, 1-bit E, 4-bit operation code)

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- reset_in  input  1  reset, asynchronous, active-high
- start_in  input  1  request strobe; sampled only in IDLE
- opcode_in  input  4  operation code, captured with start_in
- alu_ac_in  input  16  ALU result (combinational from current ac_out)
- alu_c_in  input  1  ALU carry result
- op_and_out, op_add_out, op_dr_out, op_inpr_out, op_complement_out, op_cir_out, op_cil_out  output  1 each  one-hot ALU operator selects
- ac_out  output  16  AC register
- e_out  output  1  E register
- busy_out  output  1  high in EXEC and DONE
- done_out  output  1  one-cycle completion pulse
- skip_out  output  1  skip condition result, valid only while done_out=1, else 0

Behaviour:

Opcode map:
- 0 NOP
- 1 AND (ALU op_and)
- 2 ADD (ALU op_add)
- 3 LDA (ALU op_dr)
- 4 INP (ALU op_inpr)
- 5 CMA (ALU op_complement)
- 6 CIR (ALU op_cir)
- 7 CIL (ALU op_cil)
- 8 CLA
- 9 CLE
- 10 CME
- 11 INC
- 12 SPA
- 13 SNA
- 14 SZA
- 15 SZE

Reset (any time, including mid-operation):
- State to IDLE; latched opcode to 0.
- ac_out=0, e_out=0.
- All op_*_out=0; busy_out=0, done_out=0, skip_out=0.
- An in-flight operation is abandoned with no partial update.

FSM states IDLE, EXEC, DONE:
- IDLE: if start_in=1 at an edge, latch opcode_in and go to EXEC; otherwise stay.
- EXEC (exactly 1 cycle):
  - Opcodes 1-7: exactly the matching op_*_out is high, all others 0.
  - Opcodes 0 and 8-15: all op_*_out are 0.
  - At the closing edge, AC/E update per the rules below; go to DONE.
- DONE (exactly 1 cycle): done_out=1, skip_out valid; return to IDLE.
- op_*_out are 0 in IDLE and DONE.

Latency and handshake:
- start accepted at edge k -> ops asserted in cycle k+1 -> registers updated at edge k+2 -> done_out high in cycle k+2.
- Next start is accepted at edge k+3, giving a 3-cycle issue interval.
- start_in while busy_out=1 is ignored and not queued.

Update rules at the end of EXEC:
- AND, LDA, INP, CMA: AC <= alu_ac_in; E unchanged. The ALU carry is 0 for these and must NOT be written to E.
- ADD, CIR, CIL: AC <= alu_ac_in; E <= alu_c_in.
- CLA: AC <= 0.
- CLE: E <= 0.
- CME: E <= ~E.
- INC: AC <= AC+1 modulo 2^16, so 16'hFFFF wraps to 0; E unchanged.
- NOP and skip tests: no register change.

Skip conditions (evaluated on AC/E as held during DONE):
- SPA: skip_out = (AC[15]==0)
- SNA: skip_out = (AC[15]==1)
- SZA: skip_out = (AC==0)
- SZE: skip_out = (E==0)
- skip_out=0 for all other opcodes.

Test Plan:
- Reset mid-EXEC of ADD: assert reset_in asynchronously -> ac_out=0, e_out=0, busy_out=0 immediately, no done_out pulse.
- Carry/E handling: AC=16'hFFFF, ALU model with DR=16'h0001, issue ADD -> op_add_out high exactly in cycle k+1, AC=16'h0000, E=1, done_out in cycle k+2. Then issue AND with DR=16'h00FF -> AC=0, E stays 1.
- Rotates: AC=16'h8001, E=0, issue CIL -> AC=16'h0002, E=1. Then CIR -> AC=16'h8001, E=0.
- INC wrap and internal ops: AC=16'hFFFF, INC -> AC=0, E unchanged. Then CME with E=0 -> E=1. CLE -> E=0. CLA from AC=16'h1234 -> AC=0. No op_*_out asserted during any of these.
- Skips: AC=16'h8000 -> SNA skip_out=1, SPA 0, SZA 0. AC=0 -> SZA 1, SPA 1. E=0 -> SZE 1. skip_out is 0 outside done_out.
- Handshake: hold start_in high continuously with opcode INC from AC=0 -> exactly one increment per 3 cycles; AC=3 after 9 cycles; starts during busy are not queued.

Source files
------------

// File: rtl/ac_executor.sv
// AC/E register sequencer for the basic computer. It runs one operation per
// request through IDLE -> EXEC -> DONE, so requests can issue every 3 cycles.
module ac_executor (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        start_in,
    input  logic [3:0]  opcode_in,
    input  logic [15:0] alu_ac_in,
    input  logic        alu_c_in,
    output logic        op_and_out,
    output logic        op_add_out,
    output logic        op_dr_out,
    output logic        op_inpr_out,
    output logic        op_complement_out,
    output logic        op_cir_out,
    output logic        op_cil_out,
    output logic [15:0] ac_out,
    output logic        e_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        skip_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_LDA = 4'd3;
    localparam logic [3:0] OP_INP = 4'd4;
    localparam logic [3:0] OP_CMA = 4'd5;
    localparam logic [3:0] OP_CIR = 4'd6;
    localparam logic [3:0] OP_CIL = 4'd7;
    localparam logic [3:0] OP_CLA = 4'd8;
    localparam logic [3:0] OP_CLE = 4'd9;
    localparam logic [3:0] OP_CME = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_SPA = 4'd12;
    localparam logic [3:0] OP_SNA = 4'd13;
    localparam logic [3:0] OP_SZA = 4'd14;
    localparam logic [3:0] OP_SZE = 4'd15;

    logic [1:0]  state;
    logic [3:0]  opcode;
    logic [15:0] ac;
    logic        e;
    logic [6:0]  sel;
    logic        skip;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state  <= IDLE;
            opcode <= 4'd0;
            ac     <= 16'd0;
            e      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        opcode <= opcode_in;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state <= DONE;
                    case (opcode)
                        // Logic/load ops report carry 0; E must keep its value.
                        OP_AND, OP_LDA, OP_INP, OP_CMA: ac <= alu_ac_in;
                        OP_ADD, OP_CIR, OP_CIL: begin
                            ac <= alu_ac_in;
                            e  <= alu_c_in;
                        end
                        OP_CLA: ac <= 16'd0;
                        OP_CLE: e  <= 1'b0;
                        OP_CME: e  <= ~e;
                        OP_INC: ac <= ac + 16'd1;
                        default: ;
                    endcase
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel = 7'd0;
        if (state == EXEC) begin
            case (opcode)
                OP_AND:  sel = 7'b0000001;
                OP_ADD:  sel = 7'b0000010;
                OP_LDA:  sel = 7'b0000100;
                OP_INP:  sel = 7'b0001000;
                OP_CMA:  sel = 7'b0010000;
                OP_CIR:  sel = 7'b0100000;
                OP_CIL:  sel = 7'b1000000;
                default: sel = 7'd0;
            endcase
        end
    end

    // Skip tests look at AC/E after the EXEC update, i.e. as held in DONE.
    always_comb begin
        skip = 1'b0;
        if (state == DONE) begin
            case (opcode)
                OP_SPA:  skip = ~ac[15];
                OP_SNA:  skip = ac[15];
                OP_SZA:  skip = (ac == 16'd0);
                OP_SZE:  skip = ~e;
                default: skip = 1'b0;
            endcase
        end
    end

    assign op_and_out        = sel[0];
    assign op_add_out        = sel[1];
    assign op_dr_out         = sel[2];
    assign op_inpr_out       = sel[3];
    assign op_complement_out = sel[4];
    assign op_cir_out        = sel[5];
    assign op_cil_out        = sel[6];
    assign ac_out            = ac;
    assign e_out             = e;
    assign busy_out          = (state != IDLE);
    assign done_out          = (state == DONE);
    assign skip_out          = skip;
endmodule
